// File: rtl/slip_timer_pkg.sv
// slip_timer_pkg: shared constants and types for slip_interval_timer.
//   - register address constants (TMR_*)
//   - control bit indices (CTL_*)
//   - ctl_t: packed control register, laid out so ctl_t'(DIN[2:0]) maps bit-for-bit
package slip_timer_pkg;

  localparam logic [1:0] TMR_RELOAD_LO = 2'd0;
  localparam logic [1:0] TMR_RELOAD_HI = 2'd1;
  localparam logic [1:0] TMR_CTRL      = 2'd2;
  localparam logic [1:0] TMR_PRE       = 2'd3;

  localparam int CTL_RUN     = 0;
  localparam int CTL_ONESHOT = 1;
  localparam int CTL_IEN     = 2;

  // Field order matches CTL_* indices: ien is MSB (bit 2), run is LSB (bit 0).
  typedef struct packed {
    logic ien;
    logic oneshot;
    logic run;
  } ctl_t;

endpackage

// File: rtl/slip_timer_prescaler.sv
// slip_timer_prescaler: PRE_W-bit down-counter producing the internal tick.
// Ports:
//   MasterClock - system clock
//   RESET       - synchronous active-high reset
//   i_en        - count enable (RUN & CKEN)
//   i_load      - reload counter from i_pre (wins over i_en)
//   i_pre       - prescale value
//   o_tick      - combinational tick: enabled strobe seen with counter at 0
module slip_timer_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             MasterClock,
  input  logic             RESET,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [PRE_W-1:0] i_pre,
  output logic             o_tick
);

  logic [PRE_W-1:0] r_p;

  assign o_tick = i_en && !i_load && (r_p == '0);

  always_ff @(posedge MasterClock) begin
    if (RESET)          r_p <= '0;
    else if (i_load)    r_p <= i_pre;
    else if (i_en) begin
      if (r_p == '0)    r_p <= i_pre;
      else              r_p <= r_p - PRE_W'(1);
    end
  end

endmodule

// File: rtl/slip_interval_timer.sv
// slip_interval_timer: programmable interval timer with reload, prescaler,
// one-shot mode and level interrupt.
// Ports:
//   MasterClock, RESET (sync, active high)
//   CKEN        - count-enable strobe
//   WR/RD/ADDR/DIN/DOUT - CPU register bus, DOUT registered on RD
//   TC          - one-cycle terminal-count pulse
//   IRQ/IACK    - level interrupt and its acknowledge strobe
// Build option: SLIP_TIMER_LATCH_EN - reading address 0 latches the count
// high bits so a following address-1 read returns a coherent value.
module slip_interval_timer
  import slip_timer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PRE_W = 8
) (
  input  logic       MasterClock,
  input  logic       RESET,
  input  logic       CKEN,
  input  logic       WR,
  input  logic       RD,
  input  logic [1:0] ADDR,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  output logic       TC,
  output logic       IRQ,
  input  logic       IACK
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic [7:0]       r_shadow;
  logic [PRE_W-1:0] r_pre;
  ctl_t             r_ctl;
  logic             r_irq;
  logic             r_tc;
  logic [7:0]       r_dout;
`ifdef SLIP_TIMER_LATCH_EN
  logic [WIDTH-9:0] r_hi_latch;
`endif

  logic             w_wr_lo, w_wr_hi, w_wr_ctl, w_wr_pre;
  ctl_t             w_new_ctl;
  logic             w_run_rise;
  logic [WIDTH-1:0] w_new_reload;
  logic             w_tick;
  logic             w_tc;
  logic [7:0]       w_hi8;
  logic [7:0]       w_pre8;
  logic [7:0]       w_rdata;

  assign w_wr_lo      = WR && (ADDR == TMR_RELOAD_LO);
  assign w_wr_hi      = WR && (ADDR == TMR_RELOAD_HI);
  assign w_wr_ctl     = WR && (ADDR == TMR_CTRL);
  assign w_wr_pre     = WR && (ADDR == TMR_PRE);
  assign w_new_ctl    = ctl_t'(DIN[CTL_IEN:CTL_RUN]);
  assign w_run_rise   = w_wr_ctl && w_new_ctl.run && !r_ctl.run;
  assign w_new_reload = {DIN[WIDTH-9:0], r_shadow};
  assign w_tc         = w_tick && (r_count == '0);

  // Prescaler only counts while running; RUN rising reloads it instead.
  slip_timer_prescaler #(.PRE_W(PRE_W)) u_pre (
    .MasterClock (MasterClock),
    .RESET       (RESET),
    .i_en        (r_ctl.run && CKEN),
    .i_load      (w_run_rise),
    .i_pre       (r_pre),
    .o_tick      (w_tick)
  );

  always_comb begin
    w_hi8 = '0;
`ifdef SLIP_TIMER_LATCH_EN
    w_hi8[WIDTH-9:0] = r_hi_latch;
`else
    w_hi8[WIDTH-9:0] = r_count[WIDTH-1:8];
`endif
    w_pre8 = '0;
    w_pre8[PRE_W-1:0] = r_pre;
    case (ADDR)
      TMR_RELOAD_LO: w_rdata = r_count[7:0];
      TMR_RELOAD_HI: w_rdata = w_hi8;
      TMR_CTRL:      w_rdata = {r_irq, 4'b0, r_ctl};
      default:       w_rdata = w_pre8;
    endcase
  end

  always_ff @(posedge MasterClock) begin
    if (RESET) begin
      r_count  <= '0;
      r_reload <= '0;
      r_shadow <= '0;
      r_pre    <= '0;
      r_ctl    <= '0;
      r_irq    <= 1'b0;
      r_tc     <= 1'b0;
      r_dout   <= '0;
`ifdef SLIP_TIMER_LATCH_EN
      r_hi_latch <= '0;
`endif
    end else begin
      r_tc <= w_tc;

      if (w_wr_lo)  r_shadow <= DIN;
      if (w_wr_hi)  r_reload <= w_new_reload;
      if (w_wr_pre) r_pre    <= DIN[PRE_W-1:0];

      // A run-rise edge loads only; a tick cannot coincide since RUN was 0.
      if (w_run_rise)                  r_count <= r_reload;
      else if (w_wr_hi && !r_ctl.run)  r_count <= w_new_reload;
      else if (w_tick)                 r_count <= w_tc ? r_reload : r_count - WIDTH'(1);

      // An explicit control write overrides the one-shot auto-stop.
      if (w_wr_ctl)                      r_ctl     <= w_new_ctl;
      else if (w_tc && r_ctl.oneshot)    r_ctl.run <= 1'b0;

      // Set beats clear when both land on the same edge.
      if (w_tc && r_ctl.ien)       r_irq <= 1'b1;
      else if (IACK || w_wr_ctl)   r_irq <= 1'b0;

      // Read data is sampled from pre-write state.
      if (RD) r_dout <= w_rdata;
`ifdef SLIP_TIMER_LATCH_EN
      if (RD && (ADDR == TMR_RELOAD_LO)) r_hi_latch <= r_count[WIDTH-1:8];
`endif
    end
  end

  assign DOUT = r_dout;
  assign TC   = r_tc;
  assign IRQ  = r_irq;

endmodule

// File: tb/tb_slip_interval_timer.sv
module tb_slip_interval_timer;

  logic       MasterClock = 1'b0;
  logic       RESET = 1'b1;
  logic       CKEN = 1'b0;
  logic       WR = 1'b0;
  logic       RD = 1'b0;
  logic [1:0] ADDR = '0;
  logic [7:0] DIN = '0;
  logic [7:0] DOUT;
  logic       TC;
  logic       IRQ;
  logic       IACK = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  slip_interval_timer #(.WIDTH(16), .PRE_W(8)) dut (
    .MasterClock (MasterClock),
    .RESET       (RESET),
    .CKEN        (CKEN),
    .WR          (WR),
    .RD          (RD),
    .ADDR        (ADDR),
    .DIN         (DIN),
    .DOUT        (DOUT),
    .TC          (TC),
    .IRQ         (IRQ),
    .IACK        (IACK)
  );

  always #5 MasterClock = ~MasterClock;

  task automatic cyc();
    @(posedge MasterClock);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    ADDR = a; DIN = d; WR = 1'b1;
    cyc();
    WR = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    ADDR = a; RD = 1'b1;
    cyc();
    RD = 1'b0;
    d = DOUT;
  endtask

  task automatic ck();
    CKEN = 1'b1;
    cyc();
    CKEN = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    RESET = 1'b1;
    cyc(); cyc();
    total_cnt++; if (DOUT !== 8'h00) $display("FAIL reset_dout: got %h want 00", DOUT); else pass_cnt++;
    total_cnt++; if (TC !== 1'b0) $display("FAIL reset_tc: got %b want 0", TC); else pass_cnt++;
    total_cnt++; if (IRQ !== 1'b0) $display("FAIL reset_irq: got %b want 0", IRQ); else pass_cnt++;
    RESET = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      total_cnt++; if (d !== 8'h00) $display("FAIL reset_reg%0d: got %h want 00", a, d); else pass_cnt++;
    end
  endtask

  task automatic test_periodic();
    logic [7:0] d, exp;
    wr(0, 8'h03); wr(1, 8'h00); wr(3, 8'h00); wr(2, 8'h01);
    rd(0, d);
    total_cnt++; if (d !== 8'h03) $display("FAIL per_start: got %h want 03", d); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      ck();
      total_cnt++; if (TC !== (i % 4 == 3)) $display("FAIL per_tc%0d: got %b want %b", i, TC, (i % 4 == 3)); else pass_cnt++;
      rd(0, d);
      exp = (i % 4 == 3) ? 8'd3 : 8'(2 - (i % 4));
      total_cnt++; if (d !== exp) $display("FAIL per_cnt%0d: got %h want %h", i, d, exp); else pass_cnt++;
    end
    wr(2, 8'h00);
  endtask

  task automatic test_oneshot();
    logic [7:0] d;
    wr(0, 8'h01); wr(1, 8'h00); wr(3, 8'h02); wr(2, 8'h07);
    for (int i = 0; i < 6; i++) begin
      ck();
      total_cnt++; if (TC !== (i == 5)) $display("FAIL os_tc%0d: got %b want %b", i, TC, (i == 5)); else pass_cnt++;
    end
    total_cnt++; if (IRQ !== 1'b1) $display("FAIL os_irq_set: got %b want 1", IRQ); else pass_cnt++;
    rd(2, d);
    total_cnt++; if (d !== 8'h86) $display("FAIL os_status: got %h want 86", d); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      ck();
      total_cnt++; if (TC !== 1'b0) $display("FAIL os_stopped%0d: got %b want 0", i, TC); else pass_cnt++;
    end
    total_cnt++; if (IRQ !== 1'b1) $display("FAIL os_irq_hold: got %b want 1", IRQ); else pass_cnt++;
    IACK = 1'b1; cyc(); IACK = 1'b0;
    total_cnt++; if (IRQ !== 1'b0) $display("FAIL os_iack: got %b want 0", IRQ); else pass_cnt++;
  endtask

  task automatic test_iack_tc();
    wr(3, 8'h00); wr(0, 8'h00); wr(1, 8'h00); wr(2, 8'h05);
    CKEN = 1'b1; IACK = 1'b1;
    cyc();
    CKEN = 1'b0; IACK = 1'b0;
    total_cnt++; if (TC !== 1'b1) $display("FAIL iacktc_tc: got %b want 1", TC); else pass_cnt++;
    total_cnt++; if (IRQ !== 1'b1) $display("FAIL iacktc_irq: got %b want 1", IRQ); else pass_cnt++;
    cyc();
    total_cnt++; if (IRQ !== 1'b1) $display("FAIL iacktc_level: got %b want 1", IRQ); else pass_cnt++;
    wr(2, 8'h00);
    total_cnt++; if (IRQ !== 1'b0) $display("FAIL ctlwr_clr: got %b want 0", IRQ); else pass_cnt++;
  endtask

  task automatic test_reload_midcount();
    logic [7:0] d;
    wr(0, 8'h03); wr(1, 8'h00); wr(2, 8'h01);
    ck();
    wr(0, 8'h10); wr(1, 8'h00);
    rd(0, d);
    total_cnt++; if (d !== 8'h02) $display("FAIL mid_unchanged: got %h want 02", d); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      ck();
      total_cnt++; if (TC !== (i == 2)) $display("FAIL mid_old%0d: got %b want %b", i, TC, (i == 2)); else pass_cnt++;
    end
    rd(0, d);
    total_cnt++; if (d !== 8'h10) $display("FAIL mid_newload: got %h want 10", d); else pass_cnt++;
    for (int i = 0; i < 17; i++) begin
      ck();
      total_cnt++; if (TC !== (i == 16)) $display("FAIL mid_new%0d: got %b want %b", i, TC, (i == 16)); else pass_cnt++;
    end
    wr(2, 8'h00);
  endtask

  task automatic test_rdwr_same();
    logic [7:0] d;
    ADDR = 2'd3; DIN = 8'h55; WR = 1'b1; RD = 1'b1;
    cyc();
    WR = 1'b0; RD = 1'b0;
    total_cnt++; if (DOUT !== 8'h00) $display("FAIL rdwr_old: got %h want 00", DOUT); else pass_cnt++;
    rd(3, d);
    total_cnt++; if (d !== 8'h55) $display("FAIL rdwr_new: got %h want 55", d); else pass_cnt++;
    wr(3, 8'h00);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    wr(0, 8'h05); wr(1, 8'h00); wr(2, 8'h05);
    ck(); ck(); ck();
    rd(0, d);
    total_cnt++; if (d !== 8'h02) $display("FAIL rst_pre: got %h want 02", d); else pass_cnt++;
    RESET = 1'b1; CKEN = 1'b1;
    cyc();
    RESET = 1'b0; CKEN = 1'b0;
    total_cnt++; if (TC !== 1'b0) $display("FAIL rst_tc: got %b want 0", TC); else pass_cnt++;
    total_cnt++; if (IRQ !== 1'b0) $display("FAIL rst_irq: got %b want 0", IRQ); else pass_cnt++;
    total_cnt++; if (DOUT !== 8'h00) $display("FAIL rst_dout: got %h want 00", DOUT); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      ck();
      total_cnt++; if (TC !== 1'b0) $display("FAIL rst_notc%0d: got %b want 0", i, TC); else pass_cnt++;
    end
    rd(2, d);
    total_cnt++; if (d !== 8'h00) $display("FAIL rst_status: got %h want 00", d); else pass_cnt++;
    rd(0, d);
    total_cnt++; if (d !== 8'h00) $display("FAIL rst_count: got %h want 00", d); else pass_cnt++;
  endtask

  task automatic test_latch();
    logic [7:0] d, exp_hi;
`ifdef SLIP_TIMER_LATCH_EN
    exp_hi = 8'h01;
`else
    exp_hi = 8'h00;
`endif
    wr(0, 8'h00); wr(1, 8'h01); wr(3, 8'h00); wr(2, 8'h01);
    rd(0, d);
    total_cnt++; if (d !== 8'h00) $display("FAIL latch_lo0: got %h want 00", d); else pass_cnt++;
    ck();
    rd(1, d);
    total_cnt++; if (d !== exp_hi) $display("FAIL latch_hi: got %h want %h", d, exp_hi); else pass_cnt++;
    cyc();
    total_cnt++; if (DOUT !== exp_hi) $display("FAIL dout_hold: got %h want %h", DOUT, exp_hi); else pass_cnt++;
    rd(0, d);
    total_cnt++; if (d !== 8'hFF) $display("FAIL latch_lo1: got %h want ff", d); else pass_cnt++;
    wr(2, 8'h00);
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_iack_tc();
    test_reload_midcount();
    test_rdwr_same();
    test_reset_mid();
    test_latch();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/slip_interval_timer.md
# slip_interval_timer

Programmable interval timer built on the Slipstream counter-cell chain. It supplies the gated count-enable that steps the chain, reloads it on terminal count and raises a CPU interrupt. It sits between the CPU register bus and the downstream event logic: the CPU programs a reload value, prescaler and mode; the block emits a one-cycle terminal-count pulse and a level interrupt held until acknowledged.

## Interface
- WIDTH, 16, counter width in bits; legal range 9..16.
- PRE_W, 8, prescaler width in bits; must be ≤ 8.

- MasterClock  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- CKEN  in  1  count-enable strobe, one MasterClock cycle wide.
- WR  in  1  register write strobe.
- RD  in  1  register read strobe.
- ADDR  in  2  register select.
- DIN  in  8  write data.
- DOUT  out  8  read data, registered.
- TC  out  1  terminal-count pulse, one cycle.
- IRQ  out  1  interrupt request, level.
- IACK  in  1  interrupt acknowledge strobe.

## Operation
- Register map, writes:
  - 0: reload low byte shadow.
  - 1: reload high byte. Commits reload = {DIN[WIDTH-9:0], shadow}; DIN bits above WIDTH-9 are ignored.
  - 2: control. Bit0 RUN, bit1 ONESHOT, bit2 IEN. Any write to control also clears IRQ.
  - 3: prescale value PRE.
- Register map, reads:
  - 0: count[7:0].
  - 1: count[WIDTH-1:8], zero-extended to 8 bits.
  - 2: {IRQ, 4'b0, IEN, ONESHOT, RUN}.
  - 3: PRE.
- Loading the count:
  - RUN rising (0→1) via a control write: count ← reload and prescaler ← PRE in the same edge.
  - High-byte write while RUN=0: count ← new reload immediately.
  - High-byte write while RUN=1: count unchanged; the new reload is used at the next terminal count.
- Prescaler: when RUN=1 and CKEN=1:
  - p == 0: internal tick fires and p ← PRE.
  - otherwise: p ← p−1.
  - PRE=0 gives one tick per CKEN.
- On tick:
  - count ≠ 0: count ← count−1.
  - count == 0: terminal count. count ← reload; TC pulses. If ONESHOT=1, RUN ← 0. If IEN=1, IRQ ← 1.
- Period: (reload+1)·(PRE+1) CKEN strobes.
- IRQ clears on IACK or a control write. If a set and a clear occur in the same cycle, the set wins.
- WR and RD in the same cycle: the write takes effect and DOUT returns the pre-write value.
- RESET: all registers, count, prescaler, RUN, IRQ, TC and DOUT go to 0. RESET asserted mid-count aborts the count; no TC is issued.

## Timing
- Write side effects are visible one edge after the WR cycle.
- DOUT is valid the cycle after RD and holds until the next RD.
- TC is high exactly one cycle: the cycle after the CKEN edge on which count was 0.
- IRQ rises in the same cycle as TC. It falls one cycle after the IACK or control-write cycle.
- CKEN while RUN=0 has no effect on count or prescaler.
- In the edge where RUN goes 0→1, a simultaneous CKEN loads only; it does not decrement.

## Configuration
- SLIP_TIMER_LATCH_EN defined:
  - A read of address 0 snapshots count[WIDTH-1:8] into a latch; address 1 returns the latch.
  - This gives a coherent 16-bit read across the two byte reads.
  - The latch resets to 0.
- SLIP_TIMER_LATCH_EN undefined: address 1 returns the live count high bits.

## Structure
- Package slip_timer_pkg holds:
  - address constants TMR_RELOAD_LO, TMR_RELOAD_HI, TMR_CTRL, TMR_PRE;
  - control bit indices CTL_RUN, CTL_ONESHOT, CTL_IEN;
  - a packed control struct typedef.
- One sub-module, slip_timer_prescaler: PRE_W down-counter taking MasterClock, RESET, enable, load and PRE, with tick as its output.
- The counter, reload and register/IRQ logic stay in the top module.

## Test plan
- Reload=3, PRE=0, RUN=1, CKEN every cycle → TC after the 4th CKEN, then every 4 CKENs; count reads 3,2,1,0,3.
- Reload=1, PRE=2, ONESHOT=1, IEN=1 → a single TC after 6 CKENs; RUN reads 0; IRQ=1 until an IACK, then 0 one cycle later.
- IACK asserted in the same cycle as a TC with IEN=1 → IRQ stays 1.
- RUN=1, write reload 0x0010 mid-count → current period finishes at the old reload, next period is 17 ticks.
- RESET asserted with count=2 → all outputs 0 next cycle; no TC; a status read returns 0x00.
- With SLIP_TIMER_LATCH_EN defined, count=0x0100: read addr0 (returns 0x00), tick to 0x00FF, read addr1 → 0x01. With the macro undefined, the same sequence → 0x00.
